// File: rtl/riscv_legacy_core_pkg.sv
`default_nettype none
//----------------------------------------------------------------------
// Module   : riscv_legacy_core_pkg
// Summary  : Shared control encodings, opcodes and immediate decode.
// Revision : 1.0
//----------------------------------------------------------------------
package riscv_legacy_core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_PASS = 4'd8
  } alu_op_e;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_IMM = 1'b1
  } alu_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } res_src_e;

  typedef enum logic {
    PC_PC4    = 1'b0,
    PC_TARGET = 1'b1
  } pc_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_BR  = 7'b1100011;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;
  localparam logic [6:0] c_OP_LUI = 7'b0110111;

  // Opcode bits are never part of an immediate, so only [31:7] is taken.
  function automatic logic [31:0] imm_ext(input logic [31:7] ins, input imm_src_e src);
    logic [31:0] v;
    case (src)
      IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   v = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_U:   v = {ins[31:12], 12'b0};
      default: v = {{20{ins[31]}}, ins[31:20]};
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_legacy_core_if.sv
`default_nettype none
//----------------------------------------------------------------------
// Module   : riscv_legacy_core_if
// Summary  : Observation bundle of decoded controls and datapath buses.
// Revision : 1.0
//----------------------------------------------------------------------
interface riscv_legacy_core_if;
  import riscv_legacy_core_pkg::*;

  logic        reg_we;
  logic        mem_we;
  imm_src_e    imm_src;
  alu_op_e     alu_ctrl;
  alu_src_e    alu_src;
  res_src_e    res_src;
  pc_src_e     pc_src;
  logic [31:0] instr;
  logic [31:0] alu_out;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_wd_data;
  logic [31:0] pc;

  modport master (
    output reg_we, mem_we, imm_src, alu_ctrl, alu_src, res_src, pc_src,
    output instr, alu_out, mem_rd_data, mem_wd_data, pc
  );

  modport slave (
    input reg_we, mem_we, imm_src, alu_ctrl, alu_src, res_src, pc_src,
    input instr, alu_out, mem_rd_data, mem_wd_data, pc
  );

endinterface
`default_nettype wire

// File: rtl/riscv_legacy_core_controller.sv
`default_nettype none
//----------------------------------------------------------------------
// Module   : riscv_legacy_core_controller
// Summary  : Combinational instruction decoder and branch resolution.
// Revision : 1.0
//----------------------------------------------------------------------
module riscv_legacy_core_controller
  import riscv_legacy_core_pkg::*;
(
  input  wire logic [6:0] op,
  input  wire logic [2:0] funct3,
  input  wire logic       funct7b5,
  input  wire logic       zero,
  output logic            reg_we,
  output logic            mem_we,
  output imm_src_e        imm_src,
  output alu_op_e         alu_ctrl,
  output alu_src_e        alu_src,
  output res_src_e        res_src,
  output pc_src_e         pc_src
);

  logic w_branch;
  logic w_jump;
  logic w_taken;

  function automatic alu_op_e dec_alu(input logic [2:0] f3, input logic sub);
    alu_op_e v;
    case (f3)
      3'b000:  v = sub ? ALU_SUB : ALU_ADD;
      3'b001:  v = ALU_SLL;
      3'b010:  v = ALU_SLT;
      3'b100:  v = ALU_XOR;
      3'b101:  v = ALU_SRL;
      3'b110:  v = ALU_OR;
      3'b111:  v = ALU_AND;
      default: v = ALU_ADD;
    endcase
    return v;
  endfunction

  always_comb begin
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    imm_src  = IMM_I;
    alu_ctrl = ALU_ADD;
    alu_src  = SRC_REG;
    res_src  = RES_ALU;
    w_branch = 1'b0;
    w_jump   = 1'b0;
    case (op)
      c_OP_LW: begin
        reg_we  = 1'b1;
        alu_src = SRC_IMM;
        res_src = RES_MEM;
      end
      c_OP_SW: begin
        mem_we  = 1'b1;
        imm_src = IMM_S;
        alu_src = SRC_IMM;
      end
      c_OP_R: begin
        reg_we   = 1'b1;
        alu_ctrl = dec_alu(funct3, funct7b5);
      end
      c_OP_I: begin
        reg_we   = 1'b1;
        alu_src  = SRC_IMM;
        alu_ctrl = dec_alu(funct3, 1'b0);
      end
      c_OP_BR: begin
        imm_src  = IMM_B;
        alu_ctrl = ALU_SUB;
        w_branch = 1'b1;
      end
      c_OP_JAL: begin
        reg_we  = 1'b1;
        imm_src = IMM_J;
        res_src = RES_PC4;
        w_jump  = 1'b1;
      end
      c_OP_LUI: begin
        reg_we   = 1'b1;
        imm_src  = IMM_U;
        alu_src  = SRC_IMM;
        alu_ctrl = ALU_PASS;
      end
      default: ;
    endcase
  end

  // Kept apart from the decode block so zero never feeds back into alu_ctrl.
  assign w_taken = w_branch & (((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero));
  assign pc_src  = (w_jump | w_taken) ? PC_TARGET : PC_PC4;

endmodule
`default_nettype wire

// File: rtl/riscv_legacy_core_datapath.sv
`default_nettype none
//----------------------------------------------------------------------
// Module   : riscv_legacy_core_datapath
// Summary  : PC register, register file, ALU and operand/result muxing.
// Revision : 1.0
//----------------------------------------------------------------------
module riscv_legacy_core_regfile (
  input  wire logic        clk,
  input  wire logic        we,
  input  wire logic [4:0]  a1,
  input  wire logic [4:0]  a2,
  input  wire logic [4:0]  a3,
  input  wire logic [31:0] wd3,
  output logic      [31:0] rd1,
  output logic      [31:0] rd2
);

  logic [31:0] _reg [0:31];

  always_ff @(posedge clk) begin
    if (we && (a3 != 5'd0)) begin
      _reg[a3] <= wd3;
    end
  end

  assign rd1 = (a1 == 5'd0) ? 32'd0 : _reg[a1];
  assign rd2 = (a2 == 5'd0) ? 32'd0 : _reg[a2];

endmodule

module riscv_legacy_core_alu
  import riscv_legacy_core_pkg::*;
(
  input  wire logic [31:0] a,
  input  wire logic [31:0] b,
  input  alu_op_e          ctrl,
  output logic      [31:0] y,
  output logic             zero
);

  always_comb begin
    y = 32'd0;
    case (ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_PASS: y = b;
      default:  y = 32'd0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

module riscv_legacy_core_datapath
  import riscv_legacy_core_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        reg_we,
  input  alu_src_e         alu_src,
  input  res_src_e         res_src,
  input  pc_src_e          pc_src,
  input  imm_src_e         imm_src,
  input  alu_op_e          alu_ctrl,
  input  wire logic [31:7] instr_hi,
  input  wire logic [31:0] mem_rd_data,
  output logic      [31:0] pc,
  output logic      [31:0] alu_out,
  output logic      [31:0] mem_wd_data,
  output logic             zero
);

  logic [31:0] r_pc = 32'd0;
  logic [31:0] w_imm;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_src_b;
  logic [31:0] w_result;
  logic [31:0] w_pc4;
  logic [31:0] w_pc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign w_imm     = imm_ext(instr_hi, imm_src);
  assign w_pc4     = r_pc + 32'd4;
  assign w_pc_next = (pc_src == PC_TARGET) ? (r_pc + w_imm) : w_pc4;
  assign w_src_b   = (alu_src == SRC_IMM) ? w_imm : w_rd2;

  always_comb begin
    case (res_src)
      RES_MEM: w_result = mem_rd_data;
      RES_PC4: w_result = w_pc4;
      default: w_result = alu_out;
    endcase
  end

  // No commit of any kind while reset is held.
  riscv_legacy_core_regfile rf (
    .clk (clk),
    .we  (reg_we & ~rst),
    .a1  (instr_hi[19:15]),
    .a2  (instr_hi[24:20]),
    .a3  (instr_hi[11:7]),
    .wd3 (w_result),
    .rd1 (w_rd1),
    .rd2 (w_rd2)
  );

  riscv_legacy_core_alu alu (
    .a    (w_rd1),
    .b    (w_src_b),
    .ctrl (alu_ctrl),
    .y    (alu_out),
    .zero (zero)
  );

  assign pc          = r_pc;
  assign mem_wd_data = w_rd2;

endmodule
`default_nettype wire

// File: rtl/riscv_legacy_core_mem.sv
`default_nettype none
//----------------------------------------------------------------------
// Module   : riscv_legacy_core_word_mem
// Summary  : Word memory, combinational read, synchronous full-word write.
// Revision : 1.0
//----------------------------------------------------------------------
module riscv_legacy_core_mem_array #(
  parameter int WORDS = 64,
  parameter int AW    = 6
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic [AW-1:0] idx,
  input  wire logic [31:0]   wd,
  output logic      [31:0]   rd
);

  logic [31:0] _mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      _mem[idx] <= wd;
    end
  end

  assign rd = _mem[idx];

endmodule

module riscv_legacy_core_word_mem #(
  parameter int WORDS = 64
) (
  input  wire logic        clk,
  input  wire logic        we,
  input  wire logic [31:0] addr,
  input  wire logic [31:0] wd,
  output logic      [31:0] rd
);

  localparam int AW = $clog2(WORDS);

  // Byte offset and out-of-range upper address bits are ignored.
  logic w_unused;
  assign w_unused = &{1'b0, addr[31:AW+2], addr[1:0]};

  riscv_legacy_core_mem_array #(
    .WORDS (WORDS),
    .AW    (AW)
  ) _mem (
    .clk (clk),
    .we  (we),
    .idx (addr[AW+1:2]),
    .wd  (wd),
    .rd  (rd)
  );

endmodule
`default_nettype wire

// File: rtl/riscv_legacy_core.sv
`default_nettype none
//----------------------------------------------------------------------
// Module   : riscv_legacy_core
// Summary  : Single-cycle RV32I subset core with local instr/data memories.
// Revision : 1.0
//----------------------------------------------------------------------
module riscv_legacy_core_rv
  import riscv_legacy_core_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  wire logic   clk,
  input  wire logic   rst,
  output logic        reg_we,
  output logic        mem_we,
  output imm_src_e    imm_src,
  output alu_op_e     alu_ctrl,
  output alu_src_e    alu_src,
  output res_src_e    res_src,
  output pc_src_e     pc_src,
  output logic [31:0] instr,
  output logic [31:0] alu_out,
  output logic [31:0] mem_rd_data,
  output logic [31:0] mem_wd_data,
  output logic [31:0] pc
);

  logic w_zero;

  riscv_legacy_core_controller ctrl (
    .op       (instr[6:0]),
    .funct3   (instr[14:12]),
    .funct7b5 (instr[30]),
    .zero     (w_zero),
    .reg_we   (reg_we),
    .mem_we   (mem_we),
    .imm_src  (imm_src),
    .alu_ctrl (alu_ctrl),
    .alu_src  (alu_src),
    .res_src  (res_src),
    .pc_src   (pc_src)
  );

  riscv_legacy_core_datapath dp (
    .clk         (clk),
    .rst         (rst),
    .reg_we      (reg_we),
    .alu_src     (alu_src),
    .res_src     (res_src),
    .pc_src      (pc_src),
    .imm_src     (imm_src),
    .alu_ctrl    (alu_ctrl),
    .instr_hi    (instr[31:7]),
    .mem_rd_data (mem_rd_data),
    .pc          (pc),
    .alu_out     (alu_out),
    .mem_wd_data (mem_wd_data),
    .zero        (w_zero)
  );

  riscv_legacy_core_word_mem #(.WORDS(IMEM_WORDS)) instr_mem (
    .clk  (clk),
    .we   (1'b0),
    .addr (pc),
    .wd   (32'd0),
    .rd   (instr)
  );

  riscv_legacy_core_word_mem #(.WORDS(DMEM_WORDS)) data_mem (
    .clk  (clk),
    .we   (mem_we & ~rst),
    .addr (alu_out),
    .wd   (mem_wd_data),
    .rd   (mem_rd_data)
  );

endmodule

module riscv_legacy_core #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  wire logic            clk,
  input  wire logic            rst,
  riscv_legacy_core_if.master  bus
);

  riscv_legacy_core_rv #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS)
  ) rv (
    .clk         (clk),
    .rst         (rst),
    .reg_we      (bus.reg_we),
    .mem_we      (bus.mem_we),
    .imm_src     (bus.imm_src),
    .alu_ctrl    (bus.alu_ctrl),
    .alu_src     (bus.alu_src),
    .res_src     (bus.res_src),
    .pc_src      (bus.pc_src),
    .instr       (bus.instr),
    .alu_out     (bus.alu_out),
    .mem_rd_data (bus.mem_rd_data),
    .mem_wd_data (bus.mem_wd_data),
    .pc          (bus.pc)
  );

endmodule
`default_nettype wire

// File: tb/tb_riscv_legacy_core.sv
`default_nettype none
//----------------------------------------------------------------------
// Module   : tb_riscv_legacy_core
// Summary  : Directed program bench for riscv_legacy_core.
// Revision : 1.0
//----------------------------------------------------------------------
module tb_riscv_legacy_core;
  import riscv_legacy_core_pkg::*;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        we;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [20];

  always #5 clk = ~clk;

  riscv_legacy_core_if bus ();

  riscv_legacy_core #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], c_OP_R};
  endfunction

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], c_OP_SW};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], c_OP_BR};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], c_OP_JAL};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.rv.instr_mem._mem._mem[i] = c_NOP;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    step();
    check(name, bus.pc, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Main program: arithmetic, logic, lui, an unknown opcode, then loads.
    vecs[0]  = '{enc_i(-1, 0, 0, 1, c_OP_I),        5'd1,  32'hffff_ffff, 1'b1};
    vecs[1]  = '{enc_i(5, 0, 0, 2, c_OP_I),         5'd2,  32'h0000_0005, 1'b1};
    vecs[2]  = '{enc_r(0, 2, 1, 0, 3),              5'd3,  32'h0000_0004, 1'b1};
    vecs[3]  = '{enc_r(32, 1, 2, 0, 4),             5'd4,  32'h0000_0006, 1'b1};
    vecs[4]  = '{enc_r(0, 2, 1, 2, 5),              5'd5,  32'h0000_0001, 1'b1};
    vecs[5]  = '{enc_r(0, 2, 1, 7, 6),              5'd6,  32'h0000_0005, 1'b1};
    vecs[6]  = '{enc_r(0, 4, 2, 6, 7),              5'd7,  32'h0000_0007, 1'b1};
    vecs[7]  = '{enc_r(0, 4, 2, 4, 8),              5'd8,  32'h0000_0003, 1'b1};
    vecs[8]  = '{enc_r(0, 2, 2, 1, 10),             5'd10, 32'h0000_00a0, 1'b1};
    vecs[9]  = '{enc_r(0, 2, 1, 5, 11),             5'd11, 32'h07ff_ffff, 1'b1};
    vecs[10] = '{enc_i(-1, 2, 4, 12, c_OP_I),       5'd12, 32'hffff_fffa, 1'b1};
    vecs[11] = '{enc_i(-1, 2, 2, 13, c_OP_I),       5'd13, 32'h0000_0000, 1'b1};
    vecs[12] = '{{20'h12345, 5'd14, c_OP_LUI},      5'd14, 32'h1234_5000, 1'b1};
    vecs[13] = '{enc_i(32'hf0, 1, 7, 15, c_OP_I),   5'd15, 32'h0000_00f0, 1'b1};
    vecs[14] = '{enc_i(32'h7ff, 0, 6, 16, c_OP_I),  5'd16, 32'h0000_07ff, 1'b1};
    vecs[15] = '{32'hffff_ffff,                     5'd31, 32'h0bad_f00d, 1'b0};
    vecs[16] = '{enc_i(-4, 9, 2, 6, c_OP_LW),       5'd6,  32'hdead_c0de, 1'b1};
    vecs[17] = '{enc_i(0, 9, 2, 6, c_OP_LW),        5'd6,  32'hdead_beef, 1'b1};
    vecs[18] = '{enc_i(4, 9, 2, 6, c_OP_LW),        5'd6,  32'hc001_c0de, 1'b1};
    vecs[19] = '{enc_i(4, 9, 2, 0, c_OP_LW),        5'd0,  32'h0000_0000, 1'b1};

    clear_imem();
    for (int i = 0; i < 20; i++) dut.rv.instr_mem._mem._mem[i] = vecs[i].instr;
    dut.rv.dp.rf._reg[0]  = 32'd0;
    dut.rv.dp.rf._reg[9]  = 32'd8;
    dut.rv.dp.rf._reg[31] = 32'h0bad_f00d;
    dut.rv.data_mem._mem._mem[1] = 32'hdead_c0de;
    dut.rv.data_mem._mem._mem[2] = 32'hdead_beef;
    dut.rv.data_mem._mem._mem[3] = 32'hc001_c0de;
    do_reset("reset_pc");
    for (int i = 0; i < 20; i++) begin
      check($sformatf("vec%0d_instr", i), bus.instr, vecs[i].instr);
      check($sformatf("vec%0d_reg_we", i), 32'(bus.reg_we), 32'(vecs[i].we));
      step();
      check($sformatf("vec%0d_x%0d", i, vecs[i].rd), dut.rv.dp.rf._reg[vecs[i].rd], vecs[i].exp);
      check($sformatf("vec%0d_pc", i), bus.pc, 32'(4 * (i + 1)));
    end

    // sw x5,4(x9): store lands in word 3, register file untouched.
    clear_imem();
    dut.rv.instr_mem._mem._mem[0] = enc_s(4, 5, 9);
    dut.rv.dp.rf._reg[5] = 32'h1234_5678;
    dut.rv.dp.rf._reg[9] = 32'd8;
    dut.rv.data_mem._mem._mem[3] = 32'd0;
    do_reset("sw_reset_pc");
    check("sw_mem_we", 32'(bus.mem_we), 32'd1);
    check("sw_reg_we", 32'(bus.reg_we), 32'd0);
    check("sw_addr", bus.alu_out, 32'd12);
    check("sw_wd", bus.mem_wd_data, 32'h1234_5678);
    step();
    check("sw_dmem3", dut.rv.data_mem._mem._mem[3], 32'h1234_5678);
    check("sw_x5", dut.rv.dp.rf._reg[5], 32'h1234_5678);
    check("sw_x9", dut.rv.dp.rf._reg[9], 32'd8);
    check("sw_mem_we_after", 32'(bus.mem_we), 32'd0);

    // beq taken, bne not taken, bne taken with negative offset back to 0.
    clear_imem();
    dut.rv.instr_mem._mem._mem[0] = enc_b(8, 0, 0, 0);
    dut.rv.instr_mem._mem._mem[2] = enc_b(8, 0, 0, 1);
    dut.rv.instr_mem._mem._mem[3] = enc_b(-12, 0, 9, 1);
    do_reset("br_reset_pc");
    check("beq_pc_src", 32'(bus.pc_src), 32'(PC_TARGET));
    step();
    check("beq_pc", bus.pc, 32'd8);
    check("bne_nt_pc_src", 32'(bus.pc_src), 32'(PC_PC4));
    step();
    check("bne_nt_pc", bus.pc, 32'd12);
    check("bne_t_pc_src", 32'(bus.pc_src), 32'(PC_TARGET));
    step();
    check("bne_t_pc", bus.pc, 32'd0);

    // jal x1,+16 at pc=4.
    clear_imem();
    dut.rv.instr_mem._mem._mem[1] = enc_j(16, 1);
    do_reset("jal_reset_pc");
    step();
    check("jal_at_pc", bus.pc, 32'd4);
    check("jal_res_src", 32'(bus.res_src), 32'(RES_PC4));
    check("jal_pc_src", 32'(bus.pc_src), 32'(PC_TARGET));
    step();
    check("jal_x1", dut.rv.dp.rf._reg[1], 32'd8);
    check("jal_pc", bus.pc, 32'd20);

    // Reset after three instructions; the fourth must not commit.
    clear_imem();
    dut.rv.instr_mem._mem._mem[0] = enc_i(7, 0, 0, 20, c_OP_I);
    dut.rv.instr_mem._mem._mem[1] = enc_i(9, 0, 0, 21, c_OP_I);
    dut.rv.instr_mem._mem._mem[2] = enc_s(0, 21, 0);
    dut.rv.instr_mem._mem._mem[3] = enc_i(3, 0, 0, 22, c_OP_I);
    dut.rv.dp.rf._reg[22] = 32'h0000_0055;
    dut.rv.data_mem._mem._mem[0] = 32'd0;
    do_reset("mid_reset_pc0");
    step();
    step();
    step();
    check("mid_pc_before", bus.pc, 32'd12);
    rst = 1'b1;
    step();
    check("mid_pc_after", bus.pc, 32'd0);
    check("mid_x20", dut.rv.dp.rf._reg[20], 32'd7);
    check("mid_x21", dut.rv.dp.rf._reg[21], 32'd9);
    check("mid_x22", dut.rv.dp.rf._reg[22], 32'h0000_0055);
    check("mid_dmem0", dut.rv.data_mem._mem._mem[0], 32'd9);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_legacy_core.md
Name: riscv_legacy_core

Overview:
Single-cycle RV32I subset processor with built-in instruction and data memories; one instruction retires per rising clock edge. The top level exposes the decoded control signals and main datapath buses as outputs for observation and debug. It is the legacy single-cycle reference core used by the per-instruction benches. Internal hierarchy: rv.dp.rf._reg[0:31] (register file), rv.instr_mem._mem._mem[] and rv.data_mem._mem._mem[] (word arrays). Benches preload these by hierarchical reference.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words
DMEM_WORDS, 64, data memory depth in 32-bit words

Ports:
clk  in  1  system clock, rising edge active
rst  in  1  synchronous, active-high reset
reg_we  out  1  register-file write enable for the current instruction
mem_we  out  1  data-memory write enable (sw)
imm_src  out  imm_src_e (3)  immediate format: I, S, B, J, U
alu_ctrl  out  alu_op_e (4)  ALU operation
alu_src  out  alu_src_e (1)  ALU operand B: register rs2 or immediate
res_src  out  res_src_e (2)  write-back source: ALU, memory, PC+4
pc_src  out  pc_src_e (1)  next PC: PC+4 or branch/jump target
instr  out  32  instruction at current PC
alu_out  out  32  ALU result, also the data-memory byte address
mem_rd_data  out  32  data-memory read word at alu_out
mem_wd_data  out  32  store data (rs2 value)
pc  out  32  current program counter

Behaviour:
- Clocking: one clock, synchronous active-high reset. At the posedge with rst=1, pc becomes 0. The pc register also has an initial value of 0. Register file and memories are not reset.
- Single-cycle operation: fetch, decode, execute and memory read are combinational from pc. At each posedge with rst=0, commit the rd write (if reg_we), the memory write (if mem_we) and the pc update.
- Instruction memory: combinational read, instr = imem[pc[31:2]]. The core never writes it.
- Data memory: word-addressed. Read is combinational: mem_rd_data = dmem[alu_out[31:2]]. Write is synchronous, full word, when mem_we=1. Low address bits are ignored.
- Register file: 32x32. Two combinational read ports (rs1, rs2) and one synchronous write port. x0 always reads 0, and writes to x0 are suppressed, so _reg[0] keeps 0.
- Supported instructions (write-back and control settings):
  - lw: I-imm, ALU add, alu_src=imm, res_src=mem, reg_we=1.
  - sw: S-imm, ALU add, mem_we=1, reg_we=0.
  - R-type add/sub/and/or/xor/slt/sll/srl: alu_src=reg, res_src=alu.
  - I-type addi/andi/ori/xori/slti.
  - beq/bne: B-imm, ALU sub. pc_src=target when the zero flag matches.
  - jal: J-imm, res_src=PC+4, pc_src=target.
  - lui: U-imm, result = imm.
- Branch/jump target = pc + sign-extended immediate. All immediates are sign-extended to 32 bits.
- Unknown opcode: treat as NOP. reg_we=0, mem_we=0, pc advances by 4.
- Arithmetic: 32-bit wraparound. slt is signed. Shift amount is the low 5 bits.
- Control outputs reflect the instruction currently at pc, combinationally.

Decomposition:
- Shared package/headers, with matching include files alu.svh and riscv/datapath.svh:
  - alu_op_e: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL.
  - alu_src_e: REG, IMM.
  - res_src_e: ALU, MEM, PC4.
  - pc_src_e: PC4, TARGET.
  - imm_src_e: I, S, B, J, U.
  - RV32I opcode constants.
- Sub-modules: controller (decoder), datapath (instance name dp, containing regfile instance rf and alu), and a generic word memory reused for instr_mem and data_mem.
- All of these are wrapped by an inner instance rv.

Test Plan:
- lw: preload x9=8 and dmem[1..3] = deadc0de, deadbeef, c001c0de; program lw x6,-4(x9); lw x6,0(x9); lw x6,4(x9); lw x0,4(x9).
  - Pulse rst, then check after each posedge: x6 = deadc0de, deadbeef, c001c0de; then x0 = 0.
- sw: x9=8, x5=12345678; sw x5,4(x9) -> after the edge dmem[3]=12345678, mem_we=1 during the instruction, reg file unchanged.
- R/I arithmetic: addi x1,x0,-1; addi x2,x0,5; add x3,x1,x2; sub x4,x2,x1; slt x5,x1,x2 -> x3=4, x4=6, x5=1.
- Branch: beq x0,x0,+8 -> pc goes 0 to 8 and pc_src=TARGET. A not-taken bne x0,x0 -> pc+4.
- jal x1,+16 at pc=4 -> x1=8, pc=20, res_src=PC4.
- Reset mid-program: assert rst after 3 instructions -> pc=0 at the next edge; registers and memory keep their values.
